sym_source_upsampler: RTL and testbench

- Test-symbol source and 4x upsampler that sits directly downstream of the clock generator in the transmit chain.
- Produces a pseudo-random 4-ASK symbol stream from a 22-bit LFSR, once per sym_clk_ena.
- Emits a zero-stuffed sample stream, one sample per sam_clk_ena: the symbol level on the first sample of each symbol, then three zeros. This feeds the pulse-shaping filter.
- Also monitors the incoming enable cadence and flags any deviation from 4 and 16 sys_clk cycles.

---
 rtl/sym_source_upsampler.sv | 143 ++++++++++++++
 tb/tb_sym_source_upsampler.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sym_source_upsampler.sv
// rtl/sym_source_upsampler.sv - 4-ASK test-symbol source, 4x zero-stuffing upsampler, enable-cadence monitor
//
// Purpose:
//   Generates pseudo-random 2-bit symbols from a 22-bit LFSR (x^22+x^21+1), one
//   per sym_clk_ena. It maps them to Gray-coded 4-ASK levels and emits a
//   zero-stuffed sample stream, one sample per sam_clk_ena. It also watches the
//   enable cadence (4 / 16 sys_clk cycles) and raises a sticky error flag.
//
// Ports:
//   sys_clk      in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   sam_clk_ena  in   sample enable pulse (every 4 cycles)
//   sym_clk_ena  in   symbol enable pulse (every 16 cycles, with sam_clk_ena)
//   run          in   source enable, sampled on sym_clk_ena
//   sample_out   out  signed 1s17 upsampled sample
//   sample_valid out  strobe when sample_out updates
//   sym_out      out  last emitted symbol bits
//   sym_valid    out  strobe when a new symbol is emitted
//   sym_count    out  emitted-symbol count, wraps
//   ena_err      out  sticky enable-cadence error
module sym_source_upsampler #(
  parameter logic [21:0]        SEED    = 22'h3FFFFF,
  parameter logic signed [17:0] LEVEL_A = 18'sd32768,
  parameter int                 COUNT_W = 16
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic               sam_clk_ena,
  input  logic               sym_clk_ena,
  input  logic               run,
  output logic [17:0]        sample_out,
  output logic               sample_valid,
  output logic [1:0]         sym_out,
  output logic               sym_valid,
  output logic [COUNT_W-1:0] sym_count,
  output logic               ena_err
);

  logic [21:0]        lfsr_q, lfsr_d;
  logic               run_q, run_d;
  logic [17:0]        sample_q, sample_d;
  logic               sample_valid_q, sample_valid_d;
  logic [1:0]         sym_q, sym_d;
  logic               sym_valid_q, sym_valid_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [2:0]         sam_gap_q, sam_gap_d;
  logic               sam_armed_q, sam_armed_d;
  logic [4:0]         sym_gap_q, sym_gap_d;
  logic               sym_armed_q, sym_armed_d;
  logic               ena_err_q, ena_err_d;

  logic        emit;
  logic        sam_bad, sym_bad;
  logic [17:0] level_a, level_3a, level;

  assign level_a  = LEVEL_A;
  assign level_3a = LEVEL_A + (LEVEL_A <<< 1);

  // Gray mapping of the symbol about to be emitted (pre-shift LFSR bits)
  always_comb begin
    level = level_3a;
    case (lfsr_q[1:0])
      2'b00:   level = -level_3a;
      2'b01:   level = -level_a;
      2'b11:   level = level_a;
      default: level = level_3a;
    endcase
  end

  always_comb begin
    // run is captured on each symbol boundary, and the freshly captured value
    // already gates the symbol starting in this same cycle
    run_d = sym_clk_ena ? run : run_q;
    emit  = sym_clk_ena & run_d;

    lfsr_d = lfsr_q;
    if (emit) begin
      // all-zero state would lock up the LFSR; reload instead of shifting
      lfsr_d = (lfsr_q == '0) ? SEED : {lfsr_q[20:0], lfsr_q[21] ^ lfsr_q[20]};
    end

    sym_d          = emit ? lfsr_q[1:0] : sym_q;
    sym_valid_d    = emit;
    count_d        = emit ? count_q + COUNT_W'(1) : count_q;
    sample_valid_d = sam_clk_ena;
    sample_d       = sam_clk_ena ? (emit ? level : 18'd0) : sample_q;
  end

  // Cadence monitor: gap counters hold cycles since the last pulse and saturate
  always_comb begin
    sam_armed_d = sam_armed_q | sam_clk_ena;
    if (sam_clk_ena)             sam_gap_d = 3'd1;
    else if (sam_gap_q != 3'd7)  sam_gap_d = sam_gap_q + 3'd1;
    else                         sam_gap_d = sam_gap_q;
    sam_bad = sam_armed_q & (sam_clk_ena ? (sam_gap_q != 3'd4) : (sam_gap_d >= 3'd5));

    sym_armed_d = sym_armed_q | sym_clk_ena;
    if (sym_clk_ena)             sym_gap_d = 5'd1;
    else if (sym_gap_q != 5'd31) sym_gap_d = sym_gap_q + 5'd1;
    else                         sym_gap_d = sym_gap_q;
    sym_bad = sym_armed_q & (sym_clk_ena ? (sym_gap_q != 5'd16) : (sym_gap_d >= 5'd17));

    ena_err_d = ena_err_q | sam_bad | sym_bad | (sym_clk_ena & ~sam_clk_ena);
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      lfsr_q         <= SEED;
      run_q          <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      sym_q          <= '0;
      sym_valid_q    <= 1'b0;
      count_q        <= '0;
      sam_gap_q      <= '0;
      sam_armed_q    <= 1'b0;
      sym_gap_q      <= '0;
      sym_armed_q    <= 1'b0;
      ena_err_q      <= 1'b0;
    end else begin
      lfsr_q         <= lfsr_d;
      run_q          <= run_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      sym_q          <= sym_d;
      sym_valid_q    <= sym_valid_d;
      count_q        <= count_d;
      sam_gap_q      <= sam_gap_d;
      sam_armed_q    <= sam_armed_d;
      sym_gap_q      <= sym_gap_d;
      sym_armed_q    <= sym_armed_d;
      ena_err_q      <= ena_err_d;
    end
  end

  assign sample_out   = sample_q;
  assign sample_valid = sample_valid_q;
  assign sym_out      = sym_q;
  assign sym_valid    = sym_valid_q;
  assign sym_count    = count_q;
  assign ena_err      = ena_err_q;

endmodule

// File: tb/tb_sym_source_upsampler.sv
// tb/tb_sym_source_upsampler.sv - scoreboard bench for sym_source_upsampler
module tb_sym_source_upsampler;
  localparam logic [21:0]        SEED    = 22'h3FFFFF;
  localparam logic signed [17:0] LEVEL_A = 18'sd32768;
  localparam int                 COUNT_W = 10;

  logic                     sys_clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     sam_clk_ena = 1'b0;
  logic                     sym_clk_ena = 1'b0;
  logic                     run = 1'b0;
  logic signed [17:0]       sample_out;
  logic                     sample_valid;
  logic [1:0]               sym_out;
  logic                     sym_valid;
  logic [COUNT_W-1:0]       sym_count;
  logic                     ena_err;

  int n_checks = 0;
  int n_errors = 0;

  sym_source_upsampler #(.SEED(SEED), .LEVEL_A(LEVEL_A), .COUNT_W(COUNT_W)) dut (
    .sys_clk(sys_clk), .reset(reset), .sam_clk_ena(sam_clk_ena),
    .sym_clk_ena(sym_clk_ena), .run(run), .sample_out(sample_out),
    .sample_valid(sample_valid), .sym_out(sym_out), .sym_valid(sym_valid),
    .sym_count(sym_count), .ena_err(ena_err)
  );

  always #5 sys_clk = ~sys_clk;

  // reference model state
  logic [21:0]        m_lfsr = SEED;
  logic [COUNT_W-1:0] m_count = '0;
  logic [1:0]         m_last = 2'b00;
  int                 exp_samp[$];
  int                 exp_bits[$];
  int                 exp_cnt[$];

  int t1_lvl[3] = '{32768, 98304, -98304};
  int t1_bits[3] = '{3, 2, 0};

  function automatic int level_of(input logic [1:0] s);
    int a;
    a = int'(LEVEL_A);
    case (s)
      2'b00:   return -3 * a;
      2'b01:   return -a;
      2'b11:   return a;
      default: return 3 * a;
    endcase
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic tick(input logic s_en, input logic y_en, input logic r);
    sam_clk_ena = s_en;
    sym_clk_ena = y_en;
    run = r;
    if (y_en && r) begin
      if (s_en) exp_samp.push_back(level_of(m_lfsr[1:0]));
      exp_bits.push_back(int'(m_lfsr[1:0]));
      m_last = m_lfsr[1:0];
      m_count++;
      exp_cnt.push_back(int'(m_count));
      m_lfsr = (m_lfsr == 22'd0) ? SEED : {m_lfsr[20:0], m_lfsr[21] ^ m_lfsr[20]};
    end else if (s_en) begin
      exp_samp.push_back(0);
    end
    @(posedge sys_clk);
    #1;
  endtask

  // phases first..last of a 16-cycle symbol; run is random off the symbol edge
  task automatic sym_phases(input logic r, input int drop, input int first, input int last);
    logic s;
    logic rr;
    for (int p = first; p <= last; p++) begin
      s  = ((p % 4) == 0) && (p != drop);
      rr = (p == 0) ? r : 1'($urandom_range(0, 1));
      tick(s, p == 0, rr);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    sam_clk_ena = 1'b0;
    sym_clk_ena = 1'b0;
    run = 1'b0;
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
    reset = 1'b0;
    m_lfsr = SEED;
    m_count = '0;
    m_last = 2'b00;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sample_out"}, int'(sample_out), 0);
    chk({tag, "_sample_valid"}, int'(sample_valid), 0);
    chk({tag, "_sym_out"}, int'(sym_out), 0);
    chk({tag, "_sym_valid"}, int'(sym_valid), 0);
    chk({tag, "_sym_count"}, int'(sym_count), 0);
  endtask

  // monitor: pops expectations whenever the DUT strobes an output
  initial begin
    forever begin
      @(negedge sys_clk);
      if (sample_valid === 1'b1) begin
        if (exp_samp.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sample_unexpected: got %0d expected none", int'(sample_out));
        end else begin
          chk("sample", int'(sample_out), exp_samp.pop_front());
        end
      end
      if (sym_valid === 1'b1) begin
        if (exp_bits.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sym_unexpected: got %0d expected none", int'(sym_out));
        end else begin
          chk("sym_bits", int'(sym_out), exp_bits.pop_front());
          chk("sym_count", int'(sym_count), exp_cnt.pop_front());
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    // reset state
    do_reset(2);
    chk_zero("reset");
    chk("reset_ena_err", int'(ena_err), 0);

    // first three symbols at clk_gen cadence
    for (int k = 0; k < 3; k++) begin
      sym_phases(1'b1, -1, 0, 0);
      chk("t1_sample", int'(sample_out), t1_lvl[k]);
      chk("t1_sym", int'(sym_out), t1_bits[k]);
      chk("t1_count", int'(sym_count), k + 1);
      chk("t1_sym_valid", int'(sym_valid), 1);
      sym_phases(1'b1, -1, 1, 1);
      chk("t1_valid_low", int'(sample_valid), 0);
      sym_phases(1'b1, -1, 2, 15);
    end
    chk("t1_ena_err", int'(ena_err), 0);

    // run low: count frozen, symbol held
    sym_phases(1'b1, -1, 0, 15);
    for (int k = 0; k < 3; k++) sym_phases(1'b0, -1, 0, 15);
    chk("t2_count_frozen", int'(sym_count), int'(m_count));
    chk("t2_sym_held", int'(sym_out), int'(m_last));

    // random run gating
    for (int k = 0; k < 40; k++) sym_phases(1'($urandom_range(0, 1)), -1, 0, 15);
    chk("t3_count", int'(sym_count), int'(m_count));
    chk("t3_ena_err", int'(ena_err), 0);

    // dropped sam pulse
    sym_phases(1'b1, 4, 0, 3);
    chk("t4_before_drop", int'(ena_err), 0);
    sym_phases(1'b1, 4, 4, 8);
    chk("t4_err_within_5", int'(ena_err), 1);
    sym_phases(1'b1, 4, 9, 15);
    for (int k = 0; k < 4; k++) sym_phases(1'b1, -1, 0, 15);
    chk("t4_err_sticky", int'(ena_err), 1);
    do_reset(1);
    chk("t4_err_cleared", int'(ena_err), 0);

    // sym without sam
    tick(1'b0, 1'b1, 1'b1);
    chk("t5_sym_no_sam", int'(ena_err), 1);
    do_reset(1);
    for (int k = 0; k < 3; k++) sym_phases(1'b1, -1, 0, 15);
    chk("t5_clean_after_reset", int'(ena_err), 0);

    // counter wrap, then reset mid-symbol
    do_reset(2);
    for (int k = 0; k < (1 << COUNT_W) + 3; k++) sym_phases(1'b1, -1, 0, 15);
    chk("t6_wrap", int'(sym_count), 3);
    chk("t6_ena_err", int'(ena_err), 0);
    sym_phases(1'b1, -1, 0, 5);
    do_reset(1);
    chk_zero("t6_midreset");
    sym_phases(1'b1, -1, 0, 0);
    chk("t6_restart_sample", int'(sample_out), 32768);
    chk("t6_restart_sym", int'(sym_out), 3);
    sym_phases(1'b1, -1, 1, 15);

    repeat (4) tick(1'b0, 1'b0, 1'b0);
    chk("samp_queue_left", exp_samp.size(), 0);
    chk("sym_queue_left", exp_bits.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
